// File: rtl/tadc_ramp_digitizer_pkg.sv
// Shared types and defaults for the time-based ADC digital back-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tadc_ramp_digitizer_pkg;

  localparam int DEF_CNT_W    = 12;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int DEF_DIS_CYC  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DIS  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/tadc_ramp_digitizer_if.sv
// Readout bundle: averaged code plus overflow flag, valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: producer holds result_o/ovf_o while result_valid_o=1 and result_ready_i=0.
interface tadc_ramp_digitizer_if #(
  parameter int CNT_W = tadc_ramp_digitizer_pkg::DEF_CNT_W
) ();

  logic [CNT_W-1:0] result_o;
  logic             result_valid_o;
  logic             result_ready_i;
  logic             ovf_o;

  modport master (
    output result_o,
    output result_valid_o,
    output ovf_o,
    input  result_ready_i
  );

  modport slave (
    input  result_o,
    input  result_valid_o,
    input  ovf_o,
    output result_ready_i
  );

endinterface

// File: rtl/tadc_ramp_digitizer_sync2.sv
// Two-flop synchronizer for asynchronous analog comparator outputs.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
module tadc_ramp_digitizer_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Resample the async input twice to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tadc_ramp_digitizer.sv
// Single-slope ramp digitizer: times the comparator trip, averages 2^AVG_LOG2 samples.
// Latency: per sample = trip cnt + 1 ramp cycle + >=DIS_CYC discharge cycles; result registered.
// Backpressure: result held in OUTPUT until accepted; no new ramp starts while held.
module tadc_ramp_digitizer
  import tadc_ramp_digitizer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int DIS_CYC  = DEF_DIS_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start_i,
  input  logic                  pulse_i,
  output logic                  conv_o,
  output logic                  busy_o,
  tadc_ramp_digitizer_if.master rd
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DT_W  = $clog2(DIS_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [DT_W-1:0]  DT_LAST  = DT_W'(DIS_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [DT_W-1:0]  dcnt;
  logic             ovf_stk;
  logic             pulse_s;
  logic             ramp_end;
  logic             dis_done;
  logic             last;

  tadc_ramp_digitizer_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pulse_i),
    .q     (pulse_s)
  );

  // A ramp ends on comparator trip or at full scale; the code is cnt either way.
  assign ramp_end = pulse_s || (cnt == CNT_MAX);
  // Discharge needs both the minimum dwell and a released comparator.
  assign dis_done = (dcnt == DT_LAST) && !pulse_s;
  assign last     = (idx == IDX_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; dropping ena aborts from any active state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_i && ena) state_nxt = ST_RAMP;
      ST_RAMP: if (ramp_end)       state_nxt = ST_DIS;
      ST_DIS:  if (dis_done)       state_nxt = last ? ST_OUT : ST_RAMP;
      ST_OUT:  if (rd.result_ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (!ena) state_nxt = ST_IDLE;
  end

  // Ramp counter, discharge timer, accumulator and sample index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      idx     <= '0;
      dcnt    <= '0;
      ovf_stk <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          acc     <= '0;
          idx     <= '0;
          dcnt    <= '0;
          ovf_stk <= 1'b0;
        end
        ST_RAMP: begin
          cnt  <= cnt + CNT_W'(1);
          dcnt <= '0;
          if (ramp_end)         acc     <= acc + ACC_W'(cnt);
          if (cnt == CNT_MAX)   ovf_stk <= 1'b1;
        end
        ST_DIS: begin
          if (dcnt != DT_LAST) dcnt <= dcnt + DT_W'(1);
          if (dis_done) begin
            cnt <= '0;
            if (!last) idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs, decoded from the next state so they switch with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_o            <= 1'b0;
      busy_o            <= 1'b0;
      rd.result_o       <= '0;
      rd.result_valid_o <= 1'b0;
      rd.ovf_o          <= 1'b0;
    end else begin
      conv_o <= (state_nxt == ST_RAMP);
      busy_o <= (state_nxt != ST_IDLE);
      if (state == ST_DIS && state_nxt == ST_OUT) begin
        rd.result_o       <= acc[ACC_W-1:AVG_LOG2];
        rd.ovf_o          <= ovf_stk;
        rd.result_valid_o <= 1'b1;
      end else if (state_nxt != ST_OUT) begin
        rd.result_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tadc_ramp_digitizer.sv
// Bench for the ramp digitizer: table of per-sample trip points with hand-computed codes,
// plus sequences for abort, async reset and back-to-back restart under held start.
// Comparator is driven on the falling clock edge; outputs are sampled there too.
module tb_tadc_ramp_digitizer;

  logic clk = 1'b0;
  logic rst_n, ena, start_i, pulse_i, conv_o, busy_o;

  tadc_ramp_digitizer_if #(.CNT_W(12)) rd ();

  tadc_ramp_digitizer #(.CNT_W(12), .AVG_LOG2(2), .DIS_CYC(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start_i (start_i),
    .pulse_i (pulse_i),
    .conv_o  (conv_o),
    .busy_o  (busy_o),
    .rd      (rd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int t0, t1, t2, t3;  // RAMP cycle at which pulse_i rises, -1 = never
    int hold;            // discharge cycles pulse_i stays high before release
    int exp_res;
    int exp_ovf;
    int exp_low;         // minimum conv_o-low cycles per discharge
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    n_tests++;
    if (act < min) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  // Runs one full conversion (four ramps) and returns the presented result.
  task automatic do_conv(input int t0, input int t1, input int t2, input int t3,
                         input int hold, input bit keep_start,
                         output int res, output int ovf, output int min_low, output bit ok);
    int trips[4];
    int n, i, low;
    trips = '{t0, t1, t2, t3};
    ok = 1'b1; res = 0; ovf = 0; min_low = 999999;
    pulse_i = 1'b0;
    start_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!conv_o && n < 50);
    if (!conv_o) begin ok = 1'b0; return; end
    if (!keep_start) start_i = 1'b0;
    for (int s = 0; s < 4; s++) begin
      i = 0;
      while (conv_o && i < 5000) begin
        if (trips[s] >= 0 && i == trips[s]) pulse_i = 1'b1;
        i++;
        @(negedge clk);
      end
      if (conv_o) begin ok = 1'b0; return; end
      low = 0;
      while (!conv_o && !rd.result_valid_o && low < 5000) begin
        low++;
        if (low == hold + 1) pulse_i = 1'b0;
        @(negedge clk);
      end
      if (low >= 5000) begin ok = 1'b0; return; end
      if (low < min_low) min_low = low;
      if ((s == 3) != (rd.result_valid_o === 1'b1)) begin ok = 1'b0; return; end
    end
    res = rd.result_o;
    ovf = rd.ovf_o;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int res, ovf, low;
    bit ok, stable, saw;

    vecs[0] = '{100, 100, 100, 100, 0, 102, 0, 16};
    vecs[1] = '{10, 11, 12, 13, 0, 13, 0, 16};
    vecs[2] = '{-1, -1, -1, -1, 0, 4095, 1, 16};
    vecs[3] = '{0, 0, 0, 0, 0, 2, 0, 16};
    vecs[4] = '{5, -1, 5, 5, 0, 1029, 1, 16};
    vecs[5] = '{4092, 0, 0, 0, 0, 1025, 0, 16};
    vecs[6] = '{4093, 0, 0, 0, 0, 1025, 1, 16};
    vecs[7] = '{20, 20, 20, 20, 40, 22, 0, 42};

    rst_n = 1'b0; ena = 1'b0; start_i = 1'b0; pulse_i = 1'b0;
    rd.result_ready_i = 1'b0;
    #12;
    check("rst conv_o", conv_o, 0);
    check("rst busy_o", busy_o, 0);
    check("rst valid", rd.result_valid_o, 0);
    check("rst ovf_o", rd.ovf_o, 0);
    check("rst result_o", rd.result_o, 0);
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      do_conv(vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].t3, vecs[v].hold, 1'b0,
              res, ovf, low, ok);
      check($sformatf("v%0d completes", v), ok, 1);
      if (ok) begin
        check($sformatf("v%0d result", v), res, vecs[v].exp_res);
        check($sformatf("v%0d ovf", v), ovf, vecs[v].exp_ovf);
        check_ge($sformatf("v%0d discharge", v), low, vecs[v].exp_low);
        stable = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (rd.result_valid_o !== 1'b1 || rd.result_o !== res[11:0]) stable = 1'b0;
        end
        check($sformatf("v%0d held", v), stable, 1);
        rd.result_ready_i = 1'b1;
        @(negedge clk);
        rd.result_ready_i = 1'b0;
        check($sformatf("v%0d valid drop", v), rd.result_valid_o, 0);
        check($sformatf("v%0d idle", v), busy_o, 0);
      end
    end

    // Ready low for 20 cycles with start held, then exactly one IDLE cycle.
    do_conv(30, 30, 30, 30, 0, 1'b1, res, ovf, low, ok);
    check("b2b completes", ok, 1);
    check("b2b result", res, 32);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rd.result_valid_o !== 1'b1 || rd.result_o !== 12'd32 || conv_o !== 1'b0) stable = 1'b0;
    end
    check("b2b held no ramp", stable, 1);
    rd.result_ready_i = 1'b1;
    @(negedge clk);
    rd.result_ready_i = 1'b0;
    check("b2b idle busy", busy_o, 0);
    check("b2b idle valid", rd.result_valid_o, 0);
    @(negedge clk);
    check("b2b restart conv", conv_o, 1);
    check("b2b restart busy", busy_o, 1);
    start_i = 1'b0; ena = 1'b0;
    @(negedge clk);
    check("b2b abort busy", busy_o, 0);
    ena = 1'b1;
    @(negedge clk);

    // Abort in the middle of the second ramp.
    start_i = 1'b1;
    saw = 1'b0;
    for (int n = 0; n < 50 && !conv_o; n++) @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 5000 && conv_o; i++) begin
      if (i == 10) pulse_i = 1'b1;
      @(negedge clk);
    end
    pulse_i = 1'b0;
    for (int i = 0; i < 5000 && !conv_o; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("abort pre conv", conv_o, 1);
    ena = 1'b0;
    @(negedge clk);
    check("abort conv_o", conv_o, 0);
    check("abort busy_o", busy_o, 0);
    ena = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (rd.result_valid_o !== 1'b0 || busy_o !== 1'b0) saw = 1'b1;
    end
    check("abort no result", saw, 0);

    // Async reset while a result is presented.
    do_conv(-1, 0, 0, 0, 0, 1'b0, res, ovf, low, ok);
    check("rstout completes", ok, 1);
    check("rstout result", res, 1025);
    check("rstout ovf", ovf, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstout conv_o", conv_o, 0);
    check("rstout busy_o", busy_o, 0);
    check("rstout valid", rd.result_valid_o, 0);
    check("rstout ovf_o", rd.ovf_o, 0);
    check("rstout result_o", rd.result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
